// File: rtl/xike_ctrl_regs_pkg.sv
// xike_regs_pkg: address map and region decode for xike_ctrl_regs.
// Layout: status at 0.., counters at CNT_BASE.., control at CTRL_BASE..STROBE_ADDR-1, strobe at 2**AW-1.
package xike_regs_pkg;
  typedef enum logic [1:0] {REG_STAT, REG_CNT, REG_CTRL, REG_STROBE} reg_region_e;
  localparam int DEF_AW = 5;
  localparam int DEF_N_STAT = 4;
  localparam int DEF_N_CNT = 2;
  function automatic int cnt_base(int n_stat);
    return n_stat;
  endfunction
  function automatic int ctrl_base(int n_stat, int n_cnt);
    return n_stat + n_cnt;
  endfunction
  function automatic int strobe_addr(int aw);
    return (1 << aw) - 1;
  endfunction
  localparam int STAT_BASE = 0;
  localparam int CNT_BASE = cnt_base(DEF_N_STAT);
  localparam int CTRL_BASE = ctrl_base(DEF_N_STAT, DEF_N_CNT);
  localparam int STROBE_ADDR = strobe_addr(DEF_AW);
  function automatic reg_region_e region_of(int a, int aw, int n_stat, int n_cnt);
    if (a < cnt_base(n_stat)) return REG_STAT;
    if (a < ctrl_base(n_stat, n_cnt)) return REG_CNT;
    if (a == strobe_addr(aw)) return REG_STROBE;
    return REG_CTRL;
  endfunction
endpackage

// File: rtl/xike_ctrl_regs_if.sv
// xike_ctrl_regs_if: host register bus (din/we/re/addr from host, dout/dout_vld back).
// master = host side, slave = register file side.
interface xike_ctrl_regs_if #(parameter int DW = 16, parameter int AW = 5);
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic [AW-1:0] addr;
  logic we;
  logic re;
  logic dout_vld;
  modport master(output din, we, re, addr, input dout, dout_vld);
  modport slave(input din, we, re, addr, output dout, dout_vld);
endinterface

// File: rtl/xike_sync_edge.sv
// xike_sync_edge: 2-FF synchroniser; o is the synchronised level (EDGE=0) or its rising edge (EDGE=1).
// Ports: clk, rst_n (sync, active-low), d (async in), o (level or one-cycle edge).
module xike_sync_edge #(parameter bit EDGE = 1'b1) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic o
);
  logic s1, s2;
  always_ff @(posedge clk)
    if (!rst_n) {s1, s2} <= '0;
    else {s1, s2} <= {d, s1};
  if (EDGE) begin : g_edge
    logic s3;
    always_ff @(posedge clk)
      if (!rst_n) s3 <= 1'b0;
      else s3 <= s2;
    // decoded from flops only, so it is high for exactly the cycle after s2 rises
    assign o = s2 & ~s3;
  end else begin : g_lvl
    assign o = s2;
  end
endmodule

// File: rtl/xike_ctrl_regs.sv
// xike_ctrl_regs: host command register file with status, saturating counters, control regs and strobe.
// Ports: clk, rst_n (sync, active-low), bus (host register bus, slave), status_in, event_in,
// ctrl_q (control register k at [k*DW +: DW]), cmd_pulse (one-cycle strobe of written data).
module xike_ctrl_regs
  import xike_regs_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 5,
  parameter int N_STAT = 4,
  parameter int N_CNT = 2,
  localparam int N_CTRL = 2**AW - N_STAT - N_CNT - 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  xike_ctrl_regs_if.slave      bus,
  input  logic [N_STAT-1:0]    status_in,
  input  logic [N_CNT-1:0]     event_in,
  output logic [N_CTRL*DW-1:0] ctrl_q,
  output logic [DW-1:0]        cmd_pulse
);
  localparam int CNT_B = cnt_base(N_STAT);
  localparam int CTRL_B = ctrl_base(N_STAT, N_CNT);
  if (N_CTRL < 1) begin : g_bad_map
    $error("xike_ctrl_regs: N_CTRL must be at least 1");
  end
  logic [N_STAT-1:0] stat;
  logic [N_CNT-1:0] ev_rise;
  logic [DW-1:0] cnt [N_CNT];
  logic [DW-1:0] ctrl [N_CTRL];
  logic [DW-1:0] rd;
  reg_region_e rgn;
  for (genvar i = 0; i < N_STAT; i++) begin : g_stat
    xike_sync_edge #(.EDGE(1'b0)) u_sync (.clk, .rst_n, .d(status_in[i]), .o(stat[i]));
  end
  for (genvar i = 0; i < N_CNT; i++) begin : g_ev
    xike_sync_edge #(.EDGE(1'b1)) u_sync (.clk, .rst_n, .d(event_in[i]), .o(ev_rise[i]));
  end
  for (genvar k = 0; k < N_CTRL; k++) begin : g_q
    assign ctrl_q[k*DW +: DW] = ctrl[k];
  end
  assign rgn = region_of(int'(bus.addr), AW, N_STAT, N_CNT);
  // strobe region falls through to the '0 default
  always_comb begin
    rd = '0;
    for (int i = 0; i < N_STAT; i++) if (rgn == REG_STAT && int'(bus.addr) == i) rd = DW'(stat[i]);
    for (int i = 0; i < N_CNT; i++) if (rgn == REG_CNT && int'(bus.addr) == CNT_B + i) rd = cnt[i];
    for (int k = 0; k < N_CTRL; k++) if (rgn == REG_CTRL && int'(bus.addr) == CTRL_B + k) rd = ctrl[k];
  end
  // rd is sampled from pre-edge state, giving read-before-write on a shared address
  always_ff @(posedge clk)
    if (!rst_n) begin
      for (int i = 0; i < N_CNT; i++) cnt[i] <= '0;
      for (int k = 0; k < N_CTRL; k++) ctrl[k] <= '0;
      cmd_pulse <= '0;
      bus.dout <= '0;
      bus.dout_vld <= 1'b0;
    end else begin
      for (int i = 0; i < N_CNT; i++)
        cnt[i] <= (bus.we && rgn == REG_CNT && int'(bus.addr) == CNT_B + i) ? '0 :
                  (ev_rise[i] && cnt[i] != '1) ? cnt[i] + DW'(1) : cnt[i];
      for (int k = 0; k < N_CTRL; k++)
        if (bus.we && rgn == REG_CTRL && int'(bus.addr) == CTRL_B + k) ctrl[k] <= bus.din;
      cmd_pulse <= (bus.we && rgn == REG_STROBE) ? bus.din : '0;
      bus.dout_vld <= bus.re;
      if (bus.re) bus.dout <= rd;
    end
endmodule

// File: tb/tb_xike_ctrl_regs.sv
// tb_xike_ctrl_regs: directed vector bench for xike_ctrl_regs (DW=16 main build, DW=2 saturation build).
module tb_xike_ctrl_regs;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  xike_ctrl_regs_if #(.DW(16), .AW(5)) bus1();
  xike_ctrl_regs_if #(.DW(2), .AW(5)) bus2();
  logic [3:0] st1, st2;
  logic [1:0] ev1, ev2;
  logic [399:0] cq1;
  logic [15:0] cp1;
  logic [49:0] cq2;
  logic [1:0] cp2;
  xike_ctrl_regs u_dut (.clk(clk), .rst_n(rst_n), .bus(bus1), .status_in(st1), .event_in(ev1),
                        .ctrl_q(cq1), .cmd_pulse(cp1));
  xike_ctrl_regs #(.DW(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2), .status_in(st2), .event_in(ev2),
                                   .ctrl_q(cq2), .cmd_pulse(cp2));
  int n_pass = 0;
  int n_tot = 0;
  typedef struct {
    logic        we;
    logic        re;
    logic [4:0]  addr;
    logic [15:0] din;
    logic [15:0] dout;
    logic        vld;
  } vec_t;
  vec_t tbl [12];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic step(input logic we, input logic re, input logic [4:0] addr, input logic [15:0] din);
    bus1.we = we;
    bus1.re = re;
    bus1.addr = addr;
    bus1.din = din;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 5'd0, 16'd0);
  endtask
  task automatic pulses(input int n);
    for (int j = 0; j < n; j++) begin
      ev1[0] = 1'b1;
      ev2[0] = 1'b1;
      idle(4);
      ev1[0] = 1'b0;
      ev2[0] = 1'b0;
      idle(4);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    {bus1.we, bus1.re, bus1.addr, bus1.din} = '0;
    {bus2.we, bus2.re, bus2.addr, bus2.din} = '0;
    st1 = '0;
    st2 = '0;
    ev1 = '0;
    ev2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout", bus1.dout, 0);
    chk("rst_vld", bus1.dout_vld, 0);
    chk("rst_outs", {31'd0, cq1 == '0 && cp1 == '0}, 1);
    chk("rst_dut2_outs", {31'd0, cq2 == '0 && cp2 == '0 && bus2.dout_vld == 1'b0}, 1);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b1, 5'(a), 16'd0);
      chk($sformatf("rdall%0d_dout", a), bus1.dout, 0);
      chk($sformatf("rdall%0d_vld", a), bus1.dout_vld, 1);
      chk($sformatf("rdall%0d_outs", a), {31'd0, cq1 == '0 && cp1 == '0}, 1);
    end
    idle(1);
    chk("idle_vld", bus1.dout_vld, 0);
    st1 = 4'b0101;
    idle(2);
    tbl[0]  = '{1'b1, 1'b0, 5'd6,  16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 5'd6,  16'h0000, 16'hBEEF, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 5'd0,  16'h1234, 16'hBEEF, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 5'd0,  16'h0000, 16'h0001, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 5'd1,  16'h0000, 16'h0000, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 5'd2,  16'h0000, 16'h0001, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 5'd31, 16'h0000, 16'h0000, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 5'd7,  16'h0001, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 5'd7,  16'h0002, 16'h0001, 1'b1};
    tbl[9]  = '{1'b0, 1'b1, 5'd7,  16'h0000, 16'h0002, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 5'd30, 16'hCAFE, 16'h0002, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 5'd30, 16'h0000, 16'hCAFE, 1'b1};
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].din);
      chk($sformatf("vec%0d_dout", i), bus1.dout, tbl[i].dout);
      chk($sformatf("vec%0d_vld", i), bus1.dout_vld, tbl[i].vld);
      if (i == 0) chk("ctrlq0_after_write", cq1[15:0], 16'hBEEF);
    end
    chk("ctrlq0", cq1[15:0], 16'hBEEF);
    chk("ctrlq1", cq1[31:16], 16'h0002);
    chk("ctrlq24", cq1[24*16 +: 16], 16'hCAFE);
    pulses(5);
    idle(3);
    bus2.re = 1'b1;
    bus2.addr = 5'd4;
    step(1'b0, 1'b1, 5'd4, 16'd0);
    bus2.re = 1'b0;
    chk("cnt0_five", bus1.dout, 16'd5);
    chk("dw2_cnt_sat", bus2.dout, 2'd3);
    step(1'b0, 1'b1, 5'd5, 16'd0);
    chk("cnt1_zero", bus1.dout, 0);
    step(1'b1, 1'b1, 5'd4, 16'h0055);
    chk("cnt0_rbw", bus1.dout, 16'd5);
    step(1'b0, 1'b1, 5'd4, 16'd0);
    chk("cnt0_cleared", bus1.dout, 0);
    ev1[1] = 1'b1;
    idle(2);
    step(1'b1, 1'b0, 5'd5, 16'hFFFF);
    step(1'b0, 1'b1, 5'd5, 16'd0);
    chk("cnt1_clr_wins", bus1.dout, 0);
    ev1[1] = 1'b0;
    idle(4);
    ev1[1] = 1'b1;
    idle(4);
    step(1'b0, 1'b1, 5'd5, 16'd0);
    chk("cnt1_one", bus1.dout, 16'd1);
    step(1'b1, 1'b0, 5'd31, 16'h00A5);
    chk("strobe_p1", cp1, 16'h00A5);
    step(1'b1, 1'b0, 5'd31, 16'h00A5);
    chk("strobe_p2", cp1, 16'h00A5);
    idle(1);
    chk("strobe_end", cp1, 0);
    idle(1);
    chk("strobe_stay0", cp1, 0);
    bus1.re = 1'b1;
    bus1.addr = 5'd7;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstmid_vld", bus1.dout_vld, 0);
    chk("rstmid_dout", bus1.dout, 0);
    chk("rstmid_ctrlq", {31'd0, cq1 == '0}, 1);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 5'd5, 16'd0);
    chk("rstmid_cnt1", bus1.dout, 0);
    step(1'b0, 1'b1, 5'd7, 16'd0);
    chk("rstmid_ctrl1", bus1.dout, 0);
    chk("rstmid_ctrl1_vld", bus1.dout_vld, 1);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
